// File: rtl/dpram_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dpram_pkg : shared types for the dual-port RAM port arbiter family
// Rev 1.0
// ---------------------------------------------------------------------------
package dpram_pkg;

    localparam int AW_DEFAULT = 10;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/dpram_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dpram_port_arbiter_if : requester and RAM-port signals of the port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface dpram_port_arbiter_if #(
    parameter int AW = dpram_pkg::AW_DEFAULT,
    parameter int DW = dpram_pkg::DW_DEFAULT
) ();

    logic          REQ0, REQ1;
    logic          WE0, WE1;
    logic          LOCK0, LOCK1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          GNT0, GNT1;
    logic          RVALID0, RVALID1;
    logic [DW-1:0] RDATA0, RDATA1;
    logic          RAM_EN, RAM_WE;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_WDATA;
    logic [DW-1:0] RAM_RDATA;

    // Requesters plus the RAM itself sit on the master side.
    modport master (
        output REQ0, REQ1, WE0, WE1, LOCK0, LOCK1, ADDR0, ADDR1, WDATA0, WDATA1,
        input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1,
        input  RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA,
        output RAM_RDATA
    );

    modport slave (
        input  REQ0, REQ1, WE0, WE1, LOCK0, LOCK1, ADDR0, ADDR1, WDATA0, WDATA1,
        output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1,
        output RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA,
        input  RAM_RDATA
    );

endinterface
`default_nettype wire

// File: rtl/dpram_rd_tag_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dpram_rd_tag_pipe : latency-matched {valid,id} shift register for read return
// Rev 1.0
// ---------------------------------------------------------------------------
module dpram_rd_tag_pipe
    import dpram_pkg::*;
#(
    parameter int RAM_LATENCY = 1
) (
    input  logic CLK48,
    input  logic RSTN,
    input  logic push_valid_i,
    input  logic push_id_i,
    output logic rvalid0_o,
    output logic rvalid1_o
);

    localparam int DEPTH = RAM_LATENCY + 1;

    rd_tag_t [DEPTH-1:0] tags_q;

    // Stage k holds the tag of the read accepted k+1 cycles ago.
    always_ff @(posedge CLK48 or negedge RSTN) begin
        if (!RSTN) begin
            tags_q <= '0;
        end else begin
            tags_q[0] <= '{valid: push_valid_i, id: push_id_i};
            for (int i = 1; i < DEPTH; i++) begin
                tags_q[i] <= tags_q[i-1];
            end
        end
    end

    assign rvalid0_o = tags_q[RAM_LATENCY].valid && !tags_q[RAM_LATENCY].id;
    assign rvalid1_o = tags_q[RAM_LATENCY].valid &&  tags_q[RAM_LATENCY].id;

endmodule
`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dpram_port_arbiter : round-robin arbiter with bounded locked bursts for one RAM port
// Rev 1.0
// ---------------------------------------------------------------------------
module dpram_port_arbiter
    import dpram_pkg::*;
#(
    parameter int AW          = AW_DEFAULT,
    parameter int DW          = DW_DEFAULT,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_HOLD    = 8
) (
    input  logic                CLK48,
    input  logic                RSTN,
    dpram_port_arbiter_if.slave bus
);

    localparam logic [8:0] MAX_HOLD_W = 9'(MAX_HOLD);

    arb_state_t    state_q;
    logic          owner_q;
    logic          last_q;
    logic          run_q;
    logic [7:0]    hold_cnt_q;
    logic          ram_en_q;
    logic          ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;

    logic          owner_req;
    logic          other_req;
    logic          arb_mode;
    logic          gnt0;
    logic          gnt1;
    logic          gnt_any;
    logic          gnt_id;
    logic          lock_g;
    logic          we_g;
    logic [AW-1:0] addr_g;
    logic [DW-1:0] wdata_g;
    logic [8:0]    hold_inc;

    assign owner_req = owner_q ? bus.REQ1 : bus.REQ0;
    assign other_req = owner_q ? bus.REQ0 : bus.REQ1;
    // An owner that drops REQ ends its tenure and the same cycle arbitrates normally.
    assign arb_mode  = (state_q == ARB) || !owner_req;

    // run_q is cleared asynchronously, so grants vanish as soon as RSTN falls.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (run_q) begin
            if (arb_mode) begin
                if (bus.REQ0 && (!bus.REQ1 || last_q)) begin
                    gnt0 = 1'b1;
                end else if (bus.REQ1) begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = !owner_q;
                gnt1 =  owner_q;
            end
        end
    end

    assign gnt_any  = gnt0 | gnt1;
    assign gnt_id   = gnt1;
    assign lock_g   = gnt1 ? bus.LOCK1  : bus.LOCK0;
    assign we_g     = gnt1 ? bus.WE1    : bus.WE0;
    assign addr_g   = gnt1 ? bus.ADDR1  : bus.ADDR0;
    assign wdata_g  = gnt1 ? bus.WDATA1 : bus.WDATA0;
    assign hold_inc = {1'b0, hold_cnt_q} + 9'd1;

    always_ff @(posedge CLK48 or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ARB;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
            run_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (arb_mode) begin
                state_q    <= ARB;
                hold_cnt_q <= '0;
                if (gnt_any) begin
                    last_q <= gnt_id;
                    if (lock_g) begin
                        state_q    <= HOLD;
                        owner_q    <= gnt_id;
                        hold_cnt_q <= 8'd1;
                    end
                end
            end else begin
                last_q <= owner_q;
                // >= so a saturated count still yields once the other side requests.
                if (!lock_g || (other_req && (hold_inc >= MAX_HOLD_W))) begin
                    state_q    <= ARB;
                    hold_cnt_q <= '0;
                end else if (hold_inc > MAX_HOLD_W) begin
                    hold_cnt_q <= MAX_HOLD_W[7:0];
                end else begin
                    hold_cnt_q <= hold_inc[7:0];
                end
            end
        end
    end

    always_ff @(posedge CLK48 or negedge RSTN) begin
        if (!RSTN) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q <= gnt_any;
            ram_we_q <= gnt_any && we_g;
            if (gnt_any) begin
                ram_addr_q  <= addr_g;
                ram_wdata_q <= wdata_g;
            end
        end
    end

    dpram_rd_tag_pipe #(
        .RAM_LATENCY (RAM_LATENCY)
    ) u_rd_tag_pipe (
        .CLK48        (CLK48),
        .RSTN         (RSTN),
        .push_valid_i (gnt_any && !we_g),
        .push_id_i    (gnt_id),
        .rvalid0_o    (bus.RVALID0),
        .rvalid1_o    (bus.RVALID1)
    );

    assign bus.GNT0      = gnt0;
    assign bus.GNT1      = gnt1;
    assign bus.RDATA0    = bus.RAM_RDATA;
    assign bus.RDATA1    = bus.RAM_RDATA;
    assign bus.RAM_EN    = ram_en_q;
    assign bus.RAM_WE    = ram_we_q;
    assign bus.RAM_ADDR  = ram_addr_q;
    assign bus.RAM_WDATA = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dpram_port_arbiter : directed self-checking bench for dpram_port_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dpram_port_arbiter;
    import dpram_pkg::*;

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] mem [1024];

    dpram_port_arbiter_if #(.AW(10), .DW(16)) bus ();

    dpram_port_arbiter #(
        .AW          (10),
        .DW          (16),
        .RAM_LATENCY (1),
        .MAX_HOLD    (8)
    ) dut (
        .CLK48 (clk),
        .RSTN  (rstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency RAM behind the arbitrated port.
    always @(posedge clk) begin
        if (bus.RAM_EN) begin
            if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
            else            bus.RAM_RDATA     <= mem[bus.RAM_ADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set0(input logic r, input logic w, input logic l,
                        input logic [9:0] a, input logic [15:0] d);
        bus.REQ0 = r; bus.WE0 = w; bus.LOCK0 = l; bus.ADDR0 = a; bus.WDATA0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l,
                        input logic [9:0] a, input logic [15:0] d);
        bus.REQ1 = r; bus.WE1 = w; bus.LOCK1 = l; bus.ADDR1 = a; bus.WDATA1 = d;
    endtask

    task automatic idle();
        set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        next_cycle();
        next_cycle();
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int beats;
        logic e0, e1, v0, v1;

        rstn = 1'b0;
        idle();

        // Reset values, with both requesters asserting.
        next_cycle();
        set0(1'b1, 1'b0, 1'b0, 10'h011, 16'h0000);
        set1(1'b1, 1'b0, 1'b0, 10'h022, 16'h0000);
        settle();
        check("rst_gnt0",    bus.GNT0,      0);
        check("rst_gnt1",    bus.GNT1,      0);
        check("rst_ram_en",  bus.RAM_EN,    0);
        check("rst_ram_we",  bus.RAM_WE,    0);
        check("rst_addr",    bus.RAM_ADDR,  0);
        check("rst_wdata",   bus.RAM_WDATA, 0);
        check("rst_rvalid0", bus.RVALID0,   0);
        check("rst_rvalid1", bus.RVALID1,   0);
        idle();
        rstn = 1'b1;

        // Basic write then read of 0x005.
        next_cycle(); set0(1'b1, 1'b1, 1'b0, 10'h005, 16'hBEEF); settle();
        check("bw_gnt0",   bus.GNT0,   1);
        check("bw_gnt1",   bus.GNT1,   0);
        check("bw_ram_en", bus.RAM_EN, 0);
        next_cycle(); set0(1'b1, 1'b0, 1'b0, 10'h005, 16'h0000); settle();
        check("br_gnt0",   bus.GNT0,      1);
        check("bw_ram_en1",bus.RAM_EN,    1);
        check("bw_ram_we", bus.RAM_WE,    1);
        check("bw_addr",   bus.RAM_ADDR,  10'h005);
        check("bw_wdata",  bus.RAM_WDATA, 16'hBEEF);
        next_cycle(); idle(); settle();
        check("br_gnt0_off", bus.GNT0,    0);
        check("br_ram_en",   bus.RAM_EN,  1);
        check("br_ram_we",   bus.RAM_WE,  0);
        check("br_rv0_early",bus.RVALID0, 0);
        next_cycle(); settle();
        check("br_ram_en_off", bus.RAM_EN,  0);
        check("br_rvalid0",    bus.RVALID0, 1);
        check("br_rdata0",     bus.RDATA0,  16'hBEEF);
        check("br_rvalid1",    bus.RVALID1, 0);

        // Seed 0x010 and 0x020 through the arbiter.
        next_cycle(); set0(1'b1, 1'b1, 1'b0, 10'h010, 16'h1111); settle();
        check("seed_gnt0", bus.GNT0, 1);
        next_cycle(); idle(); set1(1'b1, 1'b1, 1'b0, 10'h020, 16'h2222); settle();
        check("seed_gnt1", bus.GNT1, 1);
        check("seed_gnt0_off", bus.GNT0, 0);
        next_cycle(); idle();
        next_cycle();
        next_cycle();
        do_reset();

        // Contention: alternating reads, data routed to the issuer.
        beats = 0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            if (k < 4) begin
                set0(1'b1, 1'b0, 1'b0, 10'h010, 16'h0000);
                set1(1'b1, 1'b0, 1'b0, 10'h020, 16'h0000);
            end else begin
                idle();
            end
            settle();
            e0 = (k < 4) && (k % 2 == 0);
            e1 = (k < 4) && (k % 2 == 1);
            v0 = (k == 2) || (k == 4);
            v1 = (k == 3) || (k == 5);
            check($sformatf("ct_gnt0_%0d", k), bus.GNT0, e0);
            check($sformatf("ct_gnt1_%0d", k), bus.GNT1, e1);
            check($sformatf("ct_rv0_%0d", k), bus.RVALID0, v0);
            check($sformatf("ct_rv1_%0d", k), bus.RVALID1, v1);
            if (v0) check($sformatf("ct_rd0_%0d", k), bus.RDATA0, 16'h1111);
            if (v1) check($sformatf("ct_rd1_%0d", k), bus.RDATA1, 16'h2222);
            if (bus.GNT0 || bus.GNT1) beats++;
        end
        check("ct_beats", beats, 4);
        do_reset();

        // Locked burst of 4 beats, then the waiting requester.
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            set0(1'b1, 1'b0, (k < 3), 10'h010, 16'h0000);
            set1(1'b1, 1'b0, 1'b0, 10'h020, 16'h0000);
            settle();
            check($sformatf("lk_gnt0_%0d", k), bus.GNT0, (k < 4));
            check($sformatf("lk_gnt1_%0d", k), bus.GNT1, (k == 4));
        end
        next_cycle(); idle();
        do_reset();

        // Starvation bound: 8 locked beats, one for requester 1, then 0 again.
        for (int k = 0; k < 11; k++) begin
            next_cycle();
            set0(1'b1, 1'b0, 1'b1, 10'h010, 16'h0000);
            set1(1'b1, 1'b0, 1'b0, 10'h020, 16'h0000);
            settle();
            check($sformatf("sv_gnt0_%0d", k), bus.GNT0, (k != 8));
            check($sformatf("sv_gnt1_%0d", k), bus.GNT1, (k == 8));
        end
        next_cycle(); idle();
        do_reset();

        // Owner drops REQ while holding: other side granted that same cycle.
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            set0(1'b1, 1'b0, 1'b1, 10'h010, 16'h0000);
            set1(1'b1, 1'b0, 1'b0, 10'h020, 16'h0000);
            settle();
            check($sformatf("od_gnt0_%0d", k), bus.GNT0, 1);
        end
        next_cycle();
        set0(1'b0, 1'b0, 1'b1, 10'h010, 16'h0000);
        settle();
        check("od_gnt1", bus.GNT1, 1);
        check("od_gnt0", bus.GNT0, 0);
        next_cycle();
        set0(1'b1, 1'b0, 1'b1, 10'h010, 16'h0000);
        settle();
        check("od_state", dut.state_q, ARB);
        check("od_next_gnt0", bus.GNT0, 1);
        check("od_next_gnt1", bus.GNT1, 0);
        next_cycle(); idle();
        do_reset();

        // Reset one cycle after a read grant discards the read.
        next_cycle(); set0(1'b1, 1'b0, 1'b0, 10'h010, 16'h0000); settle();
        check("mr_gnt0", bus.GNT0, 1);
        next_cycle(); idle(); set1(1'b1, 1'b0, 1'b0, 10'h020, 16'h0000); settle();
        check("mr_ram_en_pre", bus.RAM_EN, 1);
        rstn = 1'b0;
        #1;
        check("mr_ram_en", bus.RAM_EN,  0);
        check("mr_gnt1",   bus.GNT1,    0);
        check("mr_rv0",    bus.RVALID0, 0);
        for (int k = 0; k < 2; k++) begin
            next_cycle(); settle();
            check($sformatf("mr_rv0_rst_%0d", k), bus.RVALID0, 0);
            check($sformatf("mr_gnt1_rst_%0d", k), bus.GNT1, 0);
        end
        next_cycle(); idle(); rstn = 1'b1; settle();
        check("mr_rv0_rel", bus.RVALID0, 0);
        for (int k = 0; k < 2; k++) begin
            next_cycle(); settle();
            check($sformatf("mr_rv0_post_%0d", k), bus.RVALID0, 0);
            check($sformatf("mr_rv1_post_%0d", k), bus.RVALID1, 0);
        end
        next_cycle();
        set0(1'b1, 1'b0, 1'b0, 10'h010, 16'h0000);
        set1(1'b1, 1'b0, 1'b0, 10'h020, 16'h0000);
        settle();
        check("mr_first_gnt0", bus.GNT0, 1);
        check("mr_first_gnt1", bus.GNT1, 0);
        next_cycle(); idle();
        next_cycle();
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
